// File: rtl/alu_pkg.sv
// Shared opcode map, control-vector width and sequencer state encoding for the ALU front end.
package alu_pkg;

  localparam int SIG_COUNT = 12;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot ALU strobe, execution length and
// rejection of opcodes the ALU cannot run (unknown op, divide by zero).
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int SIG_W   = alu_pkg::SIG_COUNT,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic [3:0]       op,
  input  logic             y_is_zero,
  output logic [SIG_W-1:0] onehot,
  output logic [3:0]       lat,
  output logic             illegal
);

  logic [SIG_W-1:0] oneBit;

  assign oneBit = {{(SIG_W-1){1'b0}}, 1'b1};

  always_comb begin
    onehot  = '0;
    lat     = 4'd1;
    illegal = 1'b0;
    if (int'(op) >= SIG_W) begin
      illegal = 1'b1;
    end else begin
      onehot = oneBit << op;
    end
    if (op == OP_MUL) begin
      lat = 4'(MUL_LAT);
    end else if (op == OP_DIV) begin
      lat = 4'(DIV_LAT);
      // A zero divisor is reported as an error instead of strobing the ALU.
      if (y_is_zero) begin
        illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the 32-bit ALU: accepts one request, strobes the ALU
// for the op's latency, captures the 64-bit result and hands it to the consumer.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = alu_pkg::SIG_COUNT,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [BITS-1:0]      req_x,
  input  logic [BITS-1:0]      req_y,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [2*BITS-1:0]    alu_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*BITS-1:0]    res_data,
  output logic                 res_err,
  output logic [CNT_BITS-1:0]  op_count
);

  seq_state_e           state_q, state_d;
  logic [BITS-1:0]      x_q, x_d;
  logic [BITS-1:0]      y_q, y_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [SIG_COUNT-1:0] ctrl_q, ctrl_d;
  logic [2*BITS-1:0]    data_q, data_d;
  logic                 err_q, err_d;
  logic [CNT_BITS-1:0]  count_q, count_d;

  logic [SIG_COUNT-1:0] decOnehot;
  logic [3:0]           decLat;
  logic                 decIllegal;

  alu_op_decode #(
    .SIG_W  (SIG_COUNT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_decode (
    .op       (req_op),
    .y_is_zero(req_y == '0),
    .onehot   (decOnehot),
    .lat      (decLat),
    .illegal  (decIllegal)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d = req_x;
          y_d = req_y;
          if (decIllegal) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = DONE;
          end else begin
            // The strobe is registered so it is glitch-free and constant through EXEC.
            cnt_d   = decLat - 4'd1;
            ctrl_d  = decOnehot;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          data_d  = alu_result;
          err_d   = 1'b0;
          ctrl_d  = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          count_d = count_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ctrl_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign alu_ctrl  = ctrl_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign res_data  = data_q;
  assign res_err   = err_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer with a behavioural ALU and reference model;
// a second instance with a 4-bit counter exercises the op_count wrap.
module tb_alu_op_sequencer;

  localparam int BITS = 32;
  localparam int SIGS = 12;

  logic        clk = 1'b0;
  logic        clr;
  logic        reqValid;
  logic [3:0]  reqOp;
  logic [31:0] reqX, reqY;
  logic        resReady;
  logic [63:0] aluResult;

  logic        reqReady, resValid, resErr;
  logic [11:0] aluCtrl;
  logic [31:0] aluX, aluY;
  logic [63:0] resData;
  logic [15:0] opCount;

  logic        reqReady2, resValid2, resErr2;
  logic [11:0] aluCtrl2;
  logic [31:0] aluX2, aluY2;
  logic [63:0] resData2;
  logic [3:0]  opCount2;

  int checks = 0;
  int errors = 0;
  int expCount = 0;
  int execAge = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .clr(clr), .req_valid(reqValid), .req_ready(reqReady),
    .req_op(reqOp), .req_x(reqX), .req_y(reqY), .alu_ctrl(aluCtrl),
    .alu_x(aluX), .alu_y(aluY), .alu_result(aluResult), .res_valid(resValid),
    .res_ready(resReady), .res_data(resData), .res_err(resErr), .op_count(opCount)
  );

  alu_op_sequencer #(.CNT_BITS(4)) dut2 (
    .clk(clk), .clr(clr), .req_valid(reqValid), .req_ready(reqReady2),
    .req_op(reqOp), .req_x(reqX), .req_y(reqY), .alu_ctrl(aluCtrl2),
    .alu_x(aluX2), .alu_y(aluY2), .alu_result(aluResult), .res_valid(resValid2),
    .res_ready(resReady), .res_data(resData2), .res_err(resErr2), .op_count(opCount2)
  );

  function automatic int latOf(input logic [3:0] op);
    if (op == 4'd2) return 4;
    if (op == 4'd3) return 8;
    return 1;
  endfunction

  function automatic logic [63:0] aluRef(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [4:0] s;
    s = y[4:0];
    case (op)
      4'd0:  return {32'd0, x + y};
      4'd1:  return {32'd0, x - y};
      4'd2:  return {32'd0, x} * {32'd0, y};
      4'd3:  return (y == 32'd0) ? 64'd0 : {x % y, x / y};
      4'd4:  return {32'd0, x >> s};
      4'd5:  return {32'd0, x << s};
      4'd6:  return {32'd0, (x >> s) | (x << (6'd32 - {1'b0, s}))};
      4'd7:  return {32'd0, (x << s) | (x >> (6'd32 - {1'b0, s}))};
      4'd8:  return {32'd0, x & y};
      4'd9:  return {32'd0, x | y};
      4'd10: return {32'd0, -x};
      4'd11: return {32'd0, ~x};
      default: return 64'h0BAD_0BAD_0BAD_0BAD;
    endcase
  endfunction

  // Behavioural multi-cycle ALU: the true result only appears in the last strobe cycle.
  always @(posedge clk) execAge <= (aluCtrl != 12'd0) ? execAge + 1 : 0;

  always_comb begin
    aluResult = 64'hA5A5_5A5A_DEAD_BEEF;
    for (int i = 0; i < SIGS; i++) begin
      if (aluCtrl == (12'd1 << i) && execAge == latOf(4'(i)) - 1)
        aluResult = aluRef(4'(i), aluX, aluY);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request at a negedge in IDLE and follows it to its handshake,
  // comparing every cycle against the reference timing; ends one negedge after the handshake.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
    logic        bad;
    int          lat;
    logic [63:0] expData;
    logic [11:0] expCtrl;
    logic [11:0] one;
    one     = 12'd1;
    bad     = (op >= 4'd12) || (op == 4'd3 && y == 32'd0);
    lat     = bad ? 0 : latOf(op);
    expData = bad ? 64'd0 : aluRef(op, x, y);
    expCtrl = bad ? 12'd0 : (one << op);
    checkOutput("idle_ready", {63'd0, reqReady}, 64'd1);
    checkOutput("idle_ready2", {63'd0, reqReady2}, 64'd1);
    reqValid = 1'b1;
    reqOp    = op;
    reqX     = x;
    reqY     = y;
    resReady = 1'($urandom_range(0, 1));
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      checkOutput("exec_ctrl", {52'd0, aluCtrl}, {52'd0, expCtrl});
      checkOutput("exec_ctrl2", {52'd0, aluCtrl2}, {52'd0, expCtrl});
      checkOutput("exec_x", {32'd0, aluX}, {32'd0, x});
      checkOutput("exec_y", {32'd0, aluY}, {32'd0, y});
      checkOutput("exec_ready", {63'd0, reqReady}, 64'd0);
      checkOutput("exec_valid", {63'd0, resValid}, 64'd0);
      reqValid = 1'($urandom_range(0, 1));
      reqOp    = 4'($urandom);
      reqX     = $urandom;
      reqY     = $urandom;
      resReady = 1'($urandom_range(0, 1));
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      checkOutput("done_valid", {63'd0, resValid}, 64'd1);
      checkOutput("done_ready", {63'd0, reqReady}, 64'd0);
      checkOutput("done_ctrl", {52'd0, aluCtrl}, 64'd0);
      checkOutput("done_data", resData, expData);
      checkOutput("done_err", {63'd0, resErr}, {63'd0, bad});
      checkOutput("done_data2", resData2, expData);
      checkOutput("done_err2", {63'd0, resErr2}, {63'd0, bad});
      checkOutput("done_valid2", {63'd0, resValid2}, 64'd1);
      reqValid = 1'($urandom_range(0, 1));
      reqOp    = 4'($urandom);
      resReady = (h == hold);
    end
    @(negedge clk);
    expCount++;
    checkOutput("post_count", {48'd0, opCount}, {48'd0, 16'(expCount)});
    checkOutput("post_count_wrap", {60'd0, opCount2}, {60'd0, 4'(expCount)});
    checkOutput("post_valid", {63'd0, resValid}, 64'd0);
    checkOutput("post_ready", {63'd0, reqReady}, 64'd1);
    checkOutput("post_ctrl", {52'd0, aluCtrl}, 64'd0);
    reqValid = 1'b0;
    resReady = 1'b0;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] rx, ry;
    clr      = 1'b1;
    reqValid = 1'b0;
    reqOp    = 4'd0;
    reqX     = 32'd0;
    reqY     = 32'd0;
    resReady = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {63'd0, reqReady}, 64'd1);
    checkOutput("rst_ctrl", {52'd0, aluCtrl}, 64'd0);
    checkOutput("rst_x", {32'd0, aluX}, 64'd0);
    checkOutput("rst_y", {32'd0, aluY}, 64'd0);
    checkOutput("rst_valid", {63'd0, resValid}, 64'd0);
    checkOutput("rst_data", resData, 64'd0);
    checkOutput("rst_err", {63'd0, resErr}, 64'd0);
    checkOutput("rst_count", {48'd0, opCount}, 64'd0);
    clr = 1'b0;

    applyStimulus(4'd0, 32'd5, 32'd7, 0);
    applyStimulus(4'd2, 32'd6, 32'd7, 1);
    applyStimulus(4'd3, 32'd100, 32'd7, 0);
    applyStimulus(4'd3, 32'd100, 32'd0, 0);
    applyStimulus(4'd13, 32'd9, 32'd9, 5);

    // Abort a divide in its second EXEC cycle.
    reqValid = 1'b1;
    reqOp    = 4'd3;
    reqX     = 32'd100;
    reqY     = 32'd7;
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("abort_exec1", {52'd0, aluCtrl}, 64'h008);
    @(negedge clk);
    checkOutput("abort_exec2", {52'd0, aluCtrl}, 64'h008);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    expCount = 0;
    checkOutput("abort_ctrl", {52'd0, aluCtrl}, 64'd0);
    checkOutput("abort_valid", {63'd0, resValid}, 64'd0);
    checkOutput("abort_count", {48'd0, opCount}, 64'd0);
    checkOutput("abort_count2", {60'd0, opCount2}, 64'd0);
    checkOutput("abort_data", resData, 64'd0);
    checkOutput("abort_err", {63'd0, resErr}, 64'd0);
    checkOutput("abort_ready", {63'd0, reqReady}, 64'd1);
    applyStimulus(4'd0, 32'd1, 32'd2, 0);

    for (int i = 0; i < 3; i++)
      applyStimulus(4'd9, $urandom, $urandom, 0);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = $urandom;
      ry  = $urandom;
      if (rop == 4'd3 && $urandom_range(0, 3) == 0) ry = 32'd0;
      applyStimulus(rop, rx, ry, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
